// File: rtl/sqr_wav_seq_ctrl.sv
// Segment-table sequencer for a square-wave generator: each table entry sets low/high
// times and a period count. The optional macro SQR_SEQ_LOOP_EN adds a `loop` input for repeated passes.
module sqr_wav_seq_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_low,
    input  logic [3:0] wr_high,
    input  logic [7:0] wr_reps,
    input  logic [2:0] last_idx,
`ifdef SQR_SEQ_LOOP_EN
    input  logic       loop,
`endif
    input  logic       start,
    input  logic       stop,
    input  logic       sqr_state,
    output logic [3:0] low_n,
    output logic [3:0] high_m,
    output logic       sqr_out,
    output logic       busy,
    output logic [2:0] seg_idx,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e     state_q;
    logic [3:0] tab_low_q  [8];
    logic [3:0] tab_high_q [8];
    logic [7:0] tab_reps_q [8];
    logic [2:0] seg_idx_q;
    logic [2:0] last_q;
    logic [3:0] low_q;
    logic [3:0] high_q;
    logic [7:0] reps_q;
    logic [7:0] cnt_q;
    logic       prev_q;
    logic       busy_q;
    logic       done_q;
    logic       loop_act;

    logic       rise_d;
    logic [7:0] cnt_d;
    logic [7:0] reps_d;
    logic       is_last_d;

    // NOTE: the table sits in registers, not RAM, because reset must clear every entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                tab_low_q[i]  <= '0;
                tab_high_q[i] <= '0;
                tab_reps_q[i] <= '0;
            end
        end else if (wr_en) begin
            tab_low_q[wr_addr]  <= wr_low;
            tab_high_q[wr_addr] <= wr_high;
            tab_reps_q[wr_addr] <= wr_reps;
        end
    end

    // The previous-sample register runs in every state, so an edge seen during LOAD is not counted later.
    always_ff @(posedge clk) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= sqr_state;
    end

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        rise_d    = sqr_state & ~prev_q;
        cnt_d     = cnt_q + 8'd1;
        is_last_d = (seg_idx_q == last_q);
        reps_d    = tab_reps_q[seg_idx_q];
        if (reps_d == 8'd0) reps_d = 8'd1;
    end

`ifdef SQR_SEQ_LOOP_EN
    logic loop_q;
    assign loop_act = loop_q;
`else
    assign loop_act = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register updates on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            seg_idx_q <= '0;
            last_q    <= '0;
            low_q     <= '0;
            high_q    <= '0;
            reps_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SQR_SEQ_LOOP_EN
            loop_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        last_q    <= last_idx;
                        seg_idx_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_LOAD;
`ifdef SQR_SEQ_LOOP_EN
                        loop_q    <= loop;
`endif
                    end
                end
                ST_LOAD: begin
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        low_q   <= tab_low_q[seg_idx_q];
                        high_q  <= tab_high_q[seg_idx_q];
                        reps_q  <= reps_d;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (rise_d && (cnt_q != 8'hFF)) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == reps_q) begin
                            if (!is_last_d) begin
                                seg_idx_q <= seg_idx_q + 3'd1;
                                state_q   <= ST_LOAD;
                            end else if (loop_act) begin
                                // A looping sequence wraps to entry 0 and stays busy.
                                done_q    <= 1'b1;
                                seg_idx_q <= '0;
                                state_q   <= ST_LOAD;
                            end else begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign low_n   = low_q;
    assign high_m  = high_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign seg_idx = seg_idx_q;
    assign sqr_out = (state_q == ST_RUN) ? sqr_state : 1'b0;

endmodule
